// File: rtl/m3_speed_ramp_ctrl_pkg.sv
// m3_speed_ramp_ctrl package: FSM state codes, mirror direction encoding,
// default parameter constants and the target clamp helper.
// Optional feature macro: M3_STALL_DET_EN (stall detector / FAULT state).
package m3_speed_ramp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_BRAKE = 3'd3,
        ST_COAST = 3'd4,
        ST_FLIP  = 3'd5,
        ST_FAULT = 3'd6
    } state_e;

    // Direction of the last INC/DEC request seen by the calculator.
    typedef enum logic {
        RDIR_INC = 1'b0,
        RDIR_DEC = 1'b1
    } rdir_e;

    localparam int unsigned DEF_ROUND_MAX = 4;
    localparam logic [7:0]  DEF_LVL_MAX   = 8'd200;
    localparam logic [15:0] DEF_COAST_CYC = 16'd1000;
`ifdef M3_STALL_DET_EN
    localparam logic [23:0] DEF_STALL_CYC = 24'd4000000;
`endif

    function automatic logic [7:0] clamp_lvl(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/m3_speed_ramp_ctrl_if.sv
// Command / calculator-control bundle of m3_speed_ramp_ctrl.
// master = command source and calculator side, slave = the sequencer.
interface m3_speed_ramp_ctrl_if;
    logic       startI;
    logic       stopI;
    logic       dirI;
    logic [7:0] targetLvlI;
    logic       nextRoundI;
    logic       clrFaultI;
    logic       workingO;
    logic       m3speedINCo;
    logic       m3speedDECo;
    logic       m3forceStopO;
    logic       m3invRotateO;
    logic [7:0] curLvlO;
    logic [2:0] stateO;
    logic       faultO;

    modport master (
        output startI, stopI, dirI, targetLvlI, nextRoundI, clrFaultI,
        input  workingO, m3speedINCo, m3speedDECo, m3forceStopO, m3invRotateO,
               curLvlO, stateO, faultO
    );

    modport slave (
        input  startI, stopI, dirI, targetLvlI, nextRoundI, clrFaultI,
        output workingO, m3speedINCo, m3speedDECo, m3forceStopO, m3invRotateO,
               curLvlO, stateO, faultO
    );
endinterface

// File: rtl/m3_speed_ramp_ctrl_round_mirror.sv
// m3_round_mirror: shadow copy of the calculator's round counter and speed
// level. It sees exactly what the calculator sees (registered INC/DEC and the
// shared nextRound pulse), so lvl tracks the calculator's level.
module m3_round_mirror
    import m3_speed_ramp_ctrl_pkg::*;
#(
    parameter int unsigned ROUND_MAX = DEF_ROUND_MAX,
    parameter logic [7:0]  LVL_MAX   = DEF_LVL_MAX
) (
    input  logic       clkI,
    input  logic       rstI,
    input  logic       clr,
    input  logic       nextRound,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] lvl
);

    localparam logic [7:0] CNT_RLD = 8'(ROUND_MAX);

    logic [7:0] lvl_q, lvl_d;
    logic [7:0] cnt_q, cnt_d;
    rdir_e      last_q, last_d;

    // Round bookkeeping: a direction change costs one round with no step.
    always_comb begin
        lvl_d  = lvl_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        if (clr) begin
            lvl_d  = 8'd0;
            cnt_d  = CNT_RLD;
            last_d = RDIR_INC;
        end else if (nextRound) begin
            if (inc) begin
                if (last_q != RDIR_INC) begin
                    cnt_d  = CNT_RLD;
                    last_d = RDIR_INC;
                end else if (cnt_q == 8'd0) begin
                    lvl_d = (lvl_q >= LVL_MAX) ? LVL_MAX : lvl_q + 8'd1;
                    cnt_d = CNT_RLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end else if (dec) begin
                if (last_q != RDIR_DEC) begin
                    cnt_d  = CNT_RLD;
                    last_d = RDIR_DEC;
                end else if (cnt_q == 8'd0) begin
                    lvl_d = (lvl_q == 8'd0) ? 8'd0 : lvl_q - 8'd1;
                    cnt_d = CNT_RLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end else begin
                cnt_d = CNT_RLD;
            end
        end
    end

    // Mirror state registers.
    always_ff @(posedge clkI) begin
        if (rstI) begin
            lvl_q  <= 8'd0;
            cnt_q  <= CNT_RLD;
            last_q <= RDIR_INC;
        end else begin
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign lvl = lvl_q;

endmodule

// File: rtl/m3_speed_ramp_ctrl.sv
// m3_speed_ramp_ctrl: sequencer above the m3 speed inc/dec calculator.
// Turns start/stop/direction/target commands into working/INC/DEC/forceStop/
// invRotate. Reversal runs brake -> coast -> flip -> restart.
// Optional macro M3_STALL_DET_EN adds a stall timer and the FAULT state.
module m3_speed_ramp_ctrl
    import m3_speed_ramp_ctrl_pkg::*;
#(
    parameter int unsigned ROUND_MAX = DEF_ROUND_MAX,
    parameter logic [7:0]  LVL_MAX   = DEF_LVL_MAX,
    parameter logic [15:0] COAST_CYC = DEF_COAST_CYC
`ifdef M3_STALL_DET_EN
  , parameter logic [23:0] STALL_CYC = DEF_STALL_CYC
`endif
) (
    input  logic               clkI,
    input  logic               rstI,
    m3_speed_ramp_ctrl_if.slave bus
);

    state_e      state_q, state_d;
    logic        work_q, work_d;
    logic        inc_q, inc_d;
    logic        dec_q, dec_d;
    logic        fs_q, fs_d;
    logic        inv_q, inv_d;
    logic [15:0] coast_q, coast_d;
    logic [7:0]  lvl;
    logic [7:0]  tgt;
    logic        brake_req;
    logic        mir_clr;

    assign tgt       = clamp_lvl(bus.targetLvlI, LVL_MAX);
    assign brake_req = bus.stopI | (bus.dirI != inv_q);
    // Calculator is held in reset whenever working is low; mirror follows.
    assign mir_clr   = ~work_q;

    m3_round_mirror #(
        .ROUND_MAX (ROUND_MAX),
        .LVL_MAX   (LVL_MAX)
    ) u_mirror (
        .clkI      (clkI),
        .rstI      (rstI),
        .clr       (mir_clr),
        .nextRound (bus.nextRoundI),
        .inc       (inc_q),
        .dec       (dec_q),
        .lvl       (lvl)
    );

`ifdef M3_STALL_DET_EN
    logic [23:0] stall_q, stall_d;
    logic        fault_q, fault_d;
    logic        stall_run;
    logic        stall_hit;

    assign stall_run = (state_q == ST_RAMP) || (state_q == ST_HOLD) || (state_q == ST_BRAKE);
    assign stall_hit = stall_run && !bus.nextRoundI && (stall_q == STALL_CYC - 24'd1);
`endif

    // Next state and next registered outputs; outputs are decoded for the
    // state being entered so they line up with stateO.
    always_comb begin
        state_d = state_q;
        work_d  = 1'b0;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        fs_d    = 1'b0;
        inv_d   = inv_q;
        coast_d = coast_q;
`ifdef M3_STALL_DET_EN
        fault_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.startI && !bus.stopI) begin
                    inv_d   = bus.dirI;
                    work_d  = 1'b1;
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP, ST_HOLD: begin
                work_d = 1'b1;
                if (brake_req) begin
                    dec_d   = 1'b1;
                    state_d = ST_BRAKE;
                end else if (lvl < tgt) begin
                    inc_d   = 1'b1;
                    state_d = ST_RAMP;
                end else if (lvl > tgt) begin
                    dec_d   = 1'b1;
                    state_d = ST_RAMP;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_BRAKE: begin
                work_d = 1'b1;
                if (lvl == 8'd0) begin
                    fs_d    = 1'b1;
                    coast_d = COAST_CYC - 16'd1;
                    state_d = ST_COAST;
                end else begin
                    dec_d = 1'b1;
                end
            end
            ST_COAST: begin
                if (coast_q == 16'd0) begin
                    // Both exits drop working: FLIP resets the calculator.
                    state_d = (bus.stopI || !bus.startI) ? ST_IDLE : ST_FLIP;
                end else begin
                    work_d  = 1'b1;
                    fs_d    = 1'b1;
                    coast_d = coast_q - 16'd1;
                end
            end
            ST_FLIP: begin
                inv_d   = bus.dirI;
                work_d  = 1'b1;
                state_d = ST_RAMP;
            end
`ifdef M3_STALL_DET_EN
            ST_FAULT: begin
                if (bus.clrFaultI) begin
                    state_d = ST_IDLE;
                end else begin
                    fs_d    = 1'b1;
                    fault_d = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef M3_STALL_DET_EN
        // Stall overrides everything else while driving.
        if (stall_hit) begin
            state_d = ST_FAULT;
            work_d  = 1'b0;
            inc_d   = 1'b0;
            dec_d   = 1'b0;
            fs_d    = 1'b1;
            fault_d = 1'b1;
        end
`endif
    end

    // FSM and output registers.
    always_ff @(posedge clkI) begin
        if (rstI) begin
            state_q <= ST_IDLE;
            work_q  <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            fs_q    <= 1'b0;
            inv_q   <= 1'b0;
            coast_q <= 16'd0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            fs_q    <= fs_d;
            inv_q   <= inv_d;
            coast_q <= coast_d;
        end
    end

`ifdef M3_STALL_DET_EN
    // Stall timer: counts driving cycles since the last round pulse or state change.
    always_comb begin
        stall_d = 24'd0;
        if (stall_run && !bus.nextRoundI && (state_d == state_q))
            stall_d = stall_q + 24'd1;
    end

    // Stall timer and fault flag registers.
    always_ff @(posedge clkI) begin
        if (rstI) begin
            stall_q <= 24'd0;
            fault_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            fault_q <= fault_d;
        end
    end

    assign bus.faultO = fault_q;
`else
    logic unused_clr_fault;
    assign unused_clr_fault = bus.clrFaultI;
    assign bus.faultO       = 1'b0;
`endif

    assign bus.workingO     = work_q;
    assign bus.m3speedINCo  = inc_q;
    assign bus.m3speedDECo  = dec_q;
    assign bus.m3forceStopO = fs_q;
    assign bus.m3invRotateO = inv_q;
    assign bus.curLvlO      = lvl;
    assign bus.stateO       = state_q;

endmodule

// File: tb/tb_m3_speed_ramp_ctrl.sv
// Bench for m3_speed_ramp_ctrl (ROUND_MAX=4, LVL_MAX=200, COAST_CYC=8,
// STALL_CYC=50 when M3_STALL_DET_EN is defined).
module tb_m3_speed_ramp_ctrl;

    localparam int RM   = 4;
    localparam int LMAX = 200;

    logic clkI = 1'b0;
    logic rstI;
    always #5 clkI = ~clkI;

    m3_speed_ramp_ctrl_if bus();

    m3_speed_ramp_ctrl #(
        .ROUND_MAX (4),
        .LVL_MAX   (8'd200),
        .COAST_CYC (16'd8)
`ifdef M3_STALL_DET_EN
      , .STALL_CYC (24'd50)
`endif
    ) dut (
        .clkI (clkI),
        .rstI (rstI),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit         start;
        bit         stop;
        bit         dir;
        logic [7:0] tgt;
        int         npulse;
        logic [7:0] lvl;
        logic [2:0] st;
        bit         inc;
        bit         dec;
        bit         work;
    } vec_t;

    localparam int NV = 10;
    vec_t vt[NV];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clkI);
        #1;
    endtask

    task automatic pulse(input int gap);
        bus.nextRoundI = 1'b1;
        tick;
        bus.nextRoundI = 1'b0;
        repeat (gap) tick;
    endtask

    task automatic do_reset;
        rstI           = 1'b1;
        bus.startI     = 1'b0;
        bus.stopI      = 1'b0;
        bus.dirI       = 1'b0;
        bus.targetLvlI = 8'd0;
        bus.nextRoundI = 1'b0;
        bus.clrFaultI  = 1'b0;
        tick;
        tick;
        rstI = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_work"},  int'(bus.workingO),     0);
        chk({tag, "_inc"},   int'(bus.m3speedINCo),  0);
        chk({tag, "_dec"},   int'(bus.m3speedDECo),  0);
        chk({tag, "_fs"},    int'(bus.m3forceStopO), 0);
        chk({tag, "_inv"},   int'(bus.m3invRotateO), 0);
        chk({tag, "_lvl"},   int'(bus.curLvlO),      0);
        chk({tag, "_state"}, int'(bus.stateO),       0);
        chk({tag, "_fault"}, int'(bus.faultO),       0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  fs_cnt;
        bit  seen_flip, seen_brake, seen_coast, bad_coast;
        int  n;
        int  m_lvl, m_cnt, m_last, tgt, tc, s, lvl_old, n_st;
        bit  m_inc, m_dec, nr, n_inc, n_dec;

        // start stop dir tgt npulse | lvl state inc dec work
        vt[0] = '{1'b1, 1'b0, 1'b0, 8'd2,   4,   8'd0,   3'd1, 1'b1, 1'b0, 1'b1};
        vt[1] = '{1'b1, 1'b0, 1'b0, 8'd2,   1,   8'd1,   3'd1, 1'b1, 1'b0, 1'b1};
        vt[2] = '{1'b1, 1'b0, 1'b0, 8'd2,   4,   8'd1,   3'd1, 1'b1, 1'b0, 1'b1};
        vt[3] = '{1'b1, 1'b0, 1'b0, 8'd2,   1,   8'd2,   3'd2, 1'b0, 1'b0, 1'b1};
        vt[4] = '{1'b1, 1'b0, 1'b0, 8'd1,   1,   8'd2,   3'd1, 1'b0, 1'b1, 1'b1};
        vt[5] = '{1'b1, 1'b0, 1'b0, 8'd1,   4,   8'd2,   3'd1, 1'b0, 1'b1, 1'b1};
        vt[6] = '{1'b1, 1'b0, 1'b0, 8'd1,   1,   8'd1,   3'd2, 1'b0, 1'b0, 1'b1};
        vt[7] = '{1'b1, 1'b0, 1'b0, 8'd255, 995, 8'd199, 3'd1, 1'b1, 1'b0, 1'b1};
        vt[8] = '{1'b1, 1'b0, 1'b0, 8'd255, 1,   8'd200, 3'd2, 1'b0, 1'b0, 1'b1};
        vt[9] = '{1'b1, 1'b0, 1'b0, 8'd255, 10,  8'd200, 3'd2, 1'b0, 1'b0, 1'b1};

        do_reset;
        chk_all_zero("reset");

        // Ramp up, hold, step down, saturate.
        for (int i = 0; i < NV; i++) begin
            bus.startI     = vt[i].start;
            bus.stopI      = vt[i].stop;
            bus.dirI       = vt[i].dir;
            bus.targetLvlI = vt[i].tgt;
            repeat (2) tick;
            for (int p = 0; p < vt[i].npulse; p++) pulse(9);
            repeat (2) tick;
            chk($sformatf("vec%0d_lvl", i),   int'(bus.curLvlO),     int'(vt[i].lvl));
            chk($sformatf("vec%0d_state", i), int'(bus.stateO),      int'(vt[i].st));
            chk($sformatf("vec%0d_inc", i),   int'(bus.m3speedINCo), int'(vt[i].inc));
            chk($sformatf("vec%0d_dec", i),   int'(bus.m3speedDECo), int'(vt[i].dec));
            chk($sformatf("vec%0d_work", i),  int'(bus.workingO),    int'(vt[i].work));
        end

        // Direction reversal: brake to 0, coast 8 clk, single-cycle flip, restart.
        do_reset;
        bus.startI = 1'b1;
        bus.targetLvlI = 8'd2;
        repeat (2) tick;
        for (int p = 0; p < 10; p++) pulse(9);
        repeat (2) tick;
        chk("rev_pre_lvl", int'(bus.curLvlO), 2);
        chk("rev_pre_state", int'(bus.stateO), 2);
        bus.dirI = 1'b1;
        tick;
        chk("rev_brake_state", int'(bus.stateO), 3);
        chk("rev_brake_dec", int'(bus.m3speedDECo), 1);
        chk("rev_brake_inv", int'(bus.m3invRotateO), 0);
        for (int p = 0; p < 10; p++) pulse(9);
        chk("rev_mid_lvl", int'(bus.curLvlO), 1);
        pulse(0);
        chk("rev_zero_lvl", int'(bus.curLvlO), 0);
        fs_cnt = 0;
        seen_flip = 1'b0;
        bad_coast = 1'b0;
        for (int i = 0; i < 40 && !seen_flip; i++) begin
            tick;
            if (bus.m3forceStopO) fs_cnt++;
            if (bus.stateO == 3'd4 && (bus.m3speedINCo || bus.m3speedDECo || !bus.m3forceStopO))
                bad_coast = 1'b1;
            if (bus.stateO == 3'd5) begin
                seen_flip = 1'b1;
                chk("flip_work", int'(bus.workingO), 0);
                chk("flip_fs", int'(bus.m3forceStopO), 0);
            end
        end
        chk("flip_seen", int'(seen_flip), 1);
        chk("coast_len", fs_cnt, 8);
        chk("coast_outputs_bad", int'(bad_coast), 0);
        tick;
        chk("restart_state", int'(bus.stateO), 1);
        chk("restart_work", int'(bus.workingO), 1);
        chk("restart_inv", int'(bus.m3invRotateO), 1);

        // Stop beats start; stop in RAMP winds down to IDLE.
        do_reset;
        bus.startI = 1'b1;
        bus.stopI  = 1'b1;
        bus.targetLvlI = 8'd2;
        repeat (3) tick;
        chk("stop_beats_start_state", int'(bus.stateO), 0);
        chk("stop_beats_start_work", int'(bus.workingO), 0);
        bus.stopI = 1'b0;
        repeat (2) tick;
        chk("stop_pre_state", int'(bus.stateO), 1);
        chk("stop_pre_inc", int'(bus.m3speedINCo), 1);
        bus.stopI = 1'b1;
        seen_brake = 1'b0;
        seen_coast = 1'b0;
        for (int i = 0; i < 60 && bus.stateO != 3'd0; i++) begin
            tick;
            if (bus.stateO == 3'd3) seen_brake = 1'b1;
            if (bus.stateO == 3'd4) seen_coast = 1'b1;
        end
        chk("stop_seen_brake", int'(seen_brake), 1);
        chk("stop_seen_coast", int'(seen_coast), 1);
        chk_all_zero("stop_idle");

        // Reset in the middle of RAMP.
        bus.stopI = 1'b0;
        repeat (3) tick;
        chk("rstmid_pre_state", int'(bus.stateO), 1);
        rstI = 1'b1;
        tick;
        chk_all_zero("rst_mid");
        rstI = 1'b0;

`ifdef M3_STALL_DET_EN
        // No round pulses while driving -> FAULT after 50 cycles.
        do_reset;
        bus.startI = 1'b1;
        bus.targetLvlI = 8'd2;
        tick;
        chk("stall_ramp_state", int'(bus.stateO), 1);
        n = 0;
        while (bus.stateO != 3'd6 && n < 100) begin
            tick;
            n++;
        end
        chk("stall_cycles", n, 50);
        chk("fault_flag", int'(bus.faultO), 1);
        chk("fault_fs", int'(bus.m3forceStopO), 1);
        chk("fault_work", int'(bus.workingO), 0);
        repeat (3) tick;
        chk("fault_sticky", int'(bus.stateO), 6);
        bus.clrFaultI = 1'b1;
        tick;
        bus.clrFaultI = 1'b0;
        chk("clr_state", int'(bus.stateO), 0);
        chk("clr_fault", int'(bus.faultO), 0);
        chk("clr_fs", int'(bus.m3forceStopO), 0);
`endif

        // Random targets and round pulses against a behavioural model.
        do_reset;
        tgt = 2;
        bus.startI = 1'b1;
        bus.targetLvlI = 8'(tgt);
        tick;
        m_lvl  = 0;
        m_cnt  = RM;
        m_last = 1;
        m_inc  = 1'b0;
        m_dec  = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0)
                tgt = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 4));
            nr = ($urandom_range(0, 2) == 0);
            bus.targetLvlI = 8'(tgt);
            bus.nextRoundI = nr;
            tc      = (tgt > LMAX) ? LMAX : tgt;
            lvl_old = m_lvl;
            s = m_inc ? 1 : (m_dec ? -1 : 0);
            if (nr) begin
                if (s == 0) m_cnt = RM;
                else if (s != m_last) begin
                    m_last = s;
                    m_cnt  = RM;
                end else if (m_cnt == 0) begin
                    m_lvl = m_lvl + s;
                    if (m_lvl < 0) m_lvl = 0;
                    if (m_lvl > LMAX) m_lvl = LMAX;
                    m_cnt = RM;
                end else m_cnt = m_cnt - 1;
            end
            n_inc = (lvl_old < tc);
            n_dec = (lvl_old > tc);
            n_st  = (lvl_old == tc) ? 2 : 1;
            m_inc = n_inc;
            m_dec = n_dec;
            tick;
            chk($sformatf("rnd%0d_lvl", c),   int'(bus.curLvlO),     m_lvl);
            chk($sformatf("rnd%0d_inc", c),   int'(bus.m3speedINCo), int'(n_inc));
            chk($sformatf("rnd%0d_dec", c),   int'(bus.m3speedDECo), int'(n_dec));
            chk($sformatf("rnd%0d_state", c), int'(bus.stateO),      n_st);
        end
        bus.nextRoundI = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
